tis_node_core: RTL and testbench

- Parametrised next-generation TIS-100 execution node: registered PC/ACC/BAK, full instruction execution, and blocking valid/ready handshakes on NPORTS neighbour ports.
- Consumes decoded fields from the program store addressed by pc.
- Replaces the purely combinational control decode with a sequencer that stalls on port I/O, applies saturating arithmetic and clamps jumps to program length.

---
 rtl/tis_node_core.sv | 183 ++++++++++++++++++
 tb/tb_tis_node_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tis_node_core.sv
// TIS-100 style execution node: PC/ACC/BAK with saturating math and stalling port I/O.
// Ports: clk/reset, decoded fields in, pc out, rd/wr handshakes, acc, stalled.
module tis_node_core #(
  parameter int DATA_W  = 11,
  parameter int SAT_MAX = 999,
  parameter int PC_W    = 4,
  parameter int NPORTS  = 4,
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [PC_W-1:0]          pc,
  input  logic [PC_W:0]            prog_len,
  input  logic [3:0]               op,
  input  logic [1:0]               src_kind,
  input  logic [PW-1:0]            src_port,
  input  logic [1:0]               dst_kind,
  input  logic [PW-1:0]            dst_port,
  input  logic signed [DATA_W-1:0] imm,
  output logic [NPORTS-1:0]        rd_req,
  input  logic [NPORTS-1:0]        rd_valid,
  input  logic [NPORTS*DATA_W-1:0] rd_data,
  output logic [NPORTS-1:0]        wr_valid,
  input  logic [NPORTS-1:0]        wr_ready,
  output logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] acc,
  output logic                     stalled
);
  localparam int XW = DATA_W + PC_W + 2;
  typedef logic signed [XW-1:0] wide_t;
  localparam wide_t SMAX = wide_t'(SAT_MAX);
  localparam wide_t ONE  = wide_t'(1);

  typedef enum logic [1:0] {RUN, RD_WAIT, WR_WAIT} state_t;
  state_t state, state_n;

  logic signed [DATA_W-1:0] bak, acc_n, bak_n;
  logic signed [DATA_W-1:0] wr_data_n, acc_x, bak_x;
  logic signed [DATA_W-1:0] rword;
  logic [PC_W-1:0] pc_n, pc_x;
  logic [NPORTS-1:0] rd_req_n, wr_valid_n;
  logic uses_src, dst_is_port, xfer;
  logic taken, resolved;
  wide_t len, last, pc_w, nxt, val;
  wide_t sum, tgt, rel;

  function automatic logic signed [DATA_W-1:0] sat(input wide_t x);
    if (x > SMAX)
      return DATA_W'(SMAX);
    else if (x < -SMAX)
      return DATA_W'(-SMAX);
    else
      return DATA_W'(x);
  endfunction

  assign uses_src = (op == 4'd1) || (op == 4'd4) ||
                    (op == 4'd5) || (op == 4'd12);
  assign dst_is_port = (op == 4'd1) && (dst_kind == 2'd2);
  assign rword = rd_data[int'(src_port)*DATA_W +: DATA_W];
  assign xfer  = |(rd_req & rd_valid);

  assign len  = (prog_len == '0) ? wide_t'(1 << PC_W)
                                 : wide_t'(prog_len);
  assign last = len - ONE;
  assign pc_w = wide_t'(pc);
  assign nxt  = (pc_w + ONE >= len) ? '0 : pc_w + ONE;
  assign tgt  = wide_t'(imm[PC_W-1:0]);

  always_comb begin
    unique case (src_kind)
      2'd0:    val = wide_t'(sat(wide_t'(imm)));
      2'd1:    val = wide_t'(acc);
      2'd2:    val = '0;
      default: val = wide_t'(sat(wide_t'(rword)));
    endcase
  end

  // Result of the instruction once its source value is known.
  always_comb begin
    acc_x = acc;
    bak_x = bak;
    pc_x  = PC_W'(nxt);
    taken = 1'b0;
    sum   = wide_t'(acc) + ((op == 4'd5) ? -val : val);
    rel   = pc_w + val;
    case (op)
      4'd1:  if (dst_kind == 2'd0) acc_x = DATA_W'(val);
      4'd2: begin
        acc_x = bak;
        bak_x = acc;
      end
      4'd3:  bak_x = acc;
      4'd4,
      4'd5:  acc_x = sat(sum);
      4'd6:  acc_x = -acc;
      4'd7:  taken = 1'b1;
      4'd8:  taken = (acc == 0);
      4'd9:  taken = (acc != 0);
      4'd10: taken = (acc > 0);
      4'd11: taken = (acc < 0);
      4'd12: begin
        if (rel < 0)
          pc_x = '0;
        else if (rel > last)
          pc_x = PC_W'(last);
        else
          pc_x = PC_W'(rel);
      end
      default: ;
    endcase
    if (taken)
      pc_x = (tgt > last) ? PC_W'(last) : PC_W'(tgt);
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    acc_n      = acc;
    bak_n      = bak;
    rd_req_n   = rd_req;
    wr_valid_n = wr_valid;
    wr_data_n  = wr_data;
    resolved   = 1'b0;
    case (state)
      RUN: begin
        resolved = !(uses_src && src_kind == 2'd3);
        if (!resolved) begin
          state_n  = RD_WAIT;
          rd_req_n = NPORTS'(1) << src_port;
        end
      end
      RD_WAIT: begin
        if (xfer) begin
          resolved = 1'b1;
          rd_req_n = '0;
        end
      end
      WR_WAIT: begin
        if (|(wr_valid & wr_ready)) begin
          wr_valid_n = '0;
          pc_n       = PC_W'(nxt);
          state_n    = RUN;
        end
      end
      default: state_n = RUN;
    endcase
    // Source known: either finish now or hand the value to a write.
    if (resolved) begin
      if (dst_is_port) begin
        state_n    = WR_WAIT;
        wr_valid_n = NPORTS'(1) << dst_port;
        wr_data_n  = DATA_W'(val);
      end else begin
        state_n = RUN;
        pc_n    = pc_x;
        acc_n   = acc_x;
        bak_n   = bak_x;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= '0;
      acc      <= '0;
      bak      <= '0;
      rd_req   <= '0;
      wr_valid <= '0;
      wr_data  <= '0;
      stalled  <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      acc      <= acc_n;
      bak      <= bak_n;
      rd_req   <= rd_req_n;
      wr_valid <= wr_valid_n;
      wr_data  <= wr_data_n;
      stalled  <= (state_n != RUN);
    end
  end
endmodule

// File: tb/tb_tis_node_core.sv
// Bench for tis_node_core: directed instructions, integer model, per-cycle compare.
// Ports: drives all DUT inputs, checks pc/acc/stalled/handshakes every negedge.
module tb_tis_node_core;
  localparam int DW  = 11;
  localparam int PCW = 4;
  localparam int NP  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [PCW-1:0]      pc;
  logic [PCW:0]        prog_len;
  logic [3:0]          op;
  logic [1:0]          src_kind, dst_kind;
  logic [1:0]          src_port, dst_port;
  logic signed [DW-1:0] imm;
  logic [NP-1:0]       rd_req, rd_valid;
  logic [NP-1:0]       wr_valid, wr_ready;
  logic [NP*DW-1:0]    rd_data;
  logic signed [DW-1:0] wr_data, acc;
  logic                stalled;

  tis_node_core dut (
    .clk(clk), .reset(reset), .pc(pc),
    .prog_len(prog_len), .op(op),
    .src_kind(src_kind), .src_port(src_port),
    .dst_kind(dst_kind), .dst_port(dst_port),
    .imm(imm), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .acc(acc),
    .stalled(stalled)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_pc = 0, m_acc = 0, m_bak = 0, plen_i = 3;
  logic [NP-1:0] e_rd = '0, e_wr = '0;
  int e_wd = 0;
  bit e_st = 1'b0;
  bit chk_en = 1'b0;

  task automatic cmp(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pc", int'(pc), m_pc);
      cmp("acc", int'(acc), m_acc);
      cmp("stalled", int'(stalled), int'(e_st));
      cmp("rd_req", int'(rd_req), int'(e_rd));
      cmp("wr_valid", int'(wr_valid), int'(e_wr));
      if (e_wr != '0)
        cmp("wr_data", int'(wr_data), e_wd);
      cmp("onehot", int'($onehot0({rd_req, wr_valid})), 1);
    end
  end

  function automatic int sat(int x);
    if (x > 999) return 999;
    if (x < -999) return -999;
    return x;
  endfunction

  function automatic int eff_len();
    return (plen_i == 0) ? 16 : plen_i;
  endfunction

  function automatic int seq_pc();
    return (m_pc + 1 >= eff_len()) ? 0 : m_pc + 1;
  endfunction

  task automatic commit(int o, int v, int dk, int im);
    int lst = eff_len() - 1;
    int nxt = seq_pc();
    int t;
    bit tk = 1'b0;
    case (o)
      1:  if (dk == 0) m_acc = v;
      2: begin
        t = m_acc; m_acc = m_bak; m_bak = t;
      end
      3:  m_bak = m_acc;
      4:  m_acc = sat(m_acc + v);
      5:  m_acc = sat(m_acc - v);
      6:  m_acc = -m_acc;
      7:  tk = 1'b1;
      8:  tk = (m_acc == 0);
      9:  tk = (m_acc != 0);
      10: tk = (m_acc > 0);
      11: tk = (m_acc < 0);
      default: ;
    endcase
    if (o == 12) begin
      t = m_pc + v;
      m_pc = (t < 0) ? 0 : (t > lst) ? lst : t;
    end else if (tk) begin
      t = im & 15;
      m_pc = (t > lst) ? lst : t;
    end else begin
      m_pc = nxt;
    end
  endtask

  task automatic set_len(int n);
    plen_i = n;
    prog_len = n[PCW:0];
  endtask

  // One instruction; rdc/wrc = cycles the request/valid stays up.
  task automatic run(int o, int sk, int sp, int dk, int dp,
                     int im, int pd, int rdc, int wrc);
    bit nrd = (o inside {1, 4, 5, 12}) && (sk == 3);
    bit nwr = (o == 1) && (dk == 2);
    logic [NP-1:0] nz = NP'(1) << ((sp + 1) % NP);
    int v;
    op = o[3:0];
    src_kind = sk[1:0];
    src_port = sp[1:0];
    dst_kind = dk[1:0];
    dst_port = dp[1:0];
    imm = im[DW-1:0];
    rd_valid = '0;
    wr_ready = '0;
    rd_data = (NP*DW)'({$urandom(), $urandom()});
    rd_data[sp*DW +: DW] = pd[DW-1:0];
    case (sk)
      0: v = sat(im);
      1: v = m_acc;
      2: v = 0;
      default: v = sat(pd);
    endcase
    if (nrd) begin
      @(posedge clk); #1;
      e_rd = NP'(1) << sp;
      e_st = 1'b1;
      for (int k = 1; k <= rdc; k++) begin
        rd_valid = nz;
        if (k == rdc) rd_valid = nz | (NP'(1) << sp);
        @(posedge clk); #1;
      end
      rd_valid = '0;
      e_rd = '0;
    end else begin
      @(posedge clk); #1;
    end
    if (nwr) begin
      e_wr = NP'(1) << dp;
      e_wd = v;
      e_st = 1'b1;
      for (int k = 1; k <= wrc; k++) begin
        wr_ready = nz;
        if (k == wrc) wr_ready = nz | (NP'(1) << dp);
        @(posedge clk); #1;
      end
      wr_ready = '0;
      e_wr = '0;
      e_st = 1'b0;
      m_pc = seq_pc();
    end else begin
      commit(o, v, dk, im);
      e_st = 1'b0;
    end
  endtask

  initial begin
    set_len(3);
    op = '0; src_kind = '0; src_port = '0;
    dst_kind = '0; dst_port = '0; imm = '0;
    rd_valid = '0; wr_ready = '0; rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    cmp("rst_pc", int'(pc), 0);
    cmp("rst_wr", int'(wr_valid), 0);
    reset = 1'b0;

    run(1, 0, 0, 0, 0, 5, 0, 1, 1);
    cmp("mov5_acc", int'(acc), 5);
    cmp("mov5_pc", int'(pc), 1);
    run(4, 0, 0, 1, 0, 997, 0, 1, 1);
    cmp("add_sat", int'(acc), 999);
    run(5, 0, 0, 1, 0, -1, 0, 1, 1);
    cmp("sub_sat", int'(acc), 999);
    cmp("wrap_pc", int'(pc), 0);

    run(1, 3, 1, 0, 0, 0, 123, 4, 1);
    cmp("rd_acc", int'(acc), 123);
    cmp("rd_pc", int'(pc), 1);
    run(1, 0, 0, 2, 2, 42, 0, 1, 4);
    cmp("wr_pc", int'(pc), 2);
    run(1, 3, 3, 2, 0, 0, -1000, 1, 1);
    run(4, 3, 0, 1, 0, 0, 7, 2, 1);
    cmp("addp_acc", int'(acc), 130);
    run(3, 0, 0, 0, 0, 0, 0, 1, 1);
    run(6, 0, 0, 0, 0, 0, 0, 1, 1);
    run(2, 0, 0, 0, 0, 0, 0, 1, 1);
    cmp("swp_acc", int'(acc), 130);
    run(2, 0, 0, 0, 0, 0, 0, 1, 1);
    run(11, 0, 0, 0, 0, 1, 0, 1, 1);
    cmp("jlz_pc", int'(pc), 1);
    run(10, 0, 0, 0, 0, 0, 0, 1, 1);
    run(5, 0, 0, 0, 0, -1024, 0, 1, 1);
    cmp("sub_neg", int'(acc), 869);
    run(4, 1, 0, 0, 0, 0, 0, 1, 1);
    run(1, 0, 0, 3, 0, 500, 0, 1, 1);
    cmp("nil_dst", int'(acc), 999);
    run(1, 2, 0, 0, 0, 77, 0, 1, 1);
    run(5, 0, 0, 0, 0, -1024, 0, 1, 1);
    run(4, 0, 0, 0, 0, -1024, 0, 1, 1);
    run(4, 0, 0, 0, 0, -1024, 0, 1, 1);
    run(4, 0, 0, 0, 0, -1024, 0, 1, 1);
    cmp("sat_low", int'(acc), -999);

    set_len(5);
    run(1, 0, 0, 0, 0, 0, 0, 1, 1);
    run(8, 0, 0, 0, 0, 7, 0, 1, 1);
    cmp("jez_clamp", int'(pc), 4);
    run(9, 0, 0, 0, 0, 2, 0, 1, 1);
    cmp("jnz_seq", int'(pc), 0);
    run(7, 0, 0, 0, 0, 1, 0, 1, 1);
    run(12, 0, 0, 0, 0, -5, 0, 1, 1);
    cmp("jro_lo", int'(pc), 0);
    set_len(6);
    run(12, 0, 0, 0, 0, 20, 0, 1, 1);
    cmp("jro_hi", int'(pc), 5);
    run(12, 3, 2, 0, 0, 0, -2, 1, 1);
    cmp("jro_port", int'(pc), 3);
    run(12, 1, 0, 0, 0, 0, 0, 1, 1);

    set_len(0);
    run(7, 0, 0, 0, 0, 15, 0, 1, 1);
    cmp("len0_jmp", int'(pc), 15);
    run(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cmp("len0_wrap", int'(pc), 0);
    run(13, 0, 0, 0, 0, 0, 0, 1, 1);
    run(1, 0, 0, 0, 0, 321, 0, 1, 1);
    run(1, 1, 0, 2, 3, 0, 0, 1, 2);

    op = 4'd1; src_kind = 2'd0; imm = 11'sd77;
    dst_kind = 2'd2; dst_port = 2'd1;
    wr_ready = '0; rd_valid = '0;
    @(posedge clk); #1;
    e_wr = 4'b0010; e_wd = 77; e_st = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    m_pc = 0; m_acc = 0; m_bak = 0;
    e_wr = '0; e_rd = '0; e_st = 1'b0;
    cmp("rst_mid_wv", int'(wr_valid), 0);
    cmp("rst_mid_pc", int'(pc), 0);
    cmp("rst_mid_acc", int'(acc), 0);
    cmp("rst_mid_st", int'(stalled), 0);
    reset = 1'b0;
    run(2, 0, 0, 0, 0, 0, 0, 1, 1);
    cmp("rst_bak", int'(acc), 0);
    cmp("rst_pc1", int'(pc), 1);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
